// File: rtl/imem_loadable.sv
// Loadable instruction memory: NOP-cleared after reset, filled through a valid/ready load port,
// read through a one-cycle-latency fetch port with fault reporting. Optional counters: IMEM_PERF_CNT_EN.
module imem_loadable #(
  parameter int              XLEN       = 32,
  parameter int              DEPTH      = 64,
  parameter int              ADDR_W     = 32,
  parameter logic [XLEN-1:0] FILL_INSTR = 32'h00000013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [XLEN-1:0]   load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_instr,
  output logic [1:0]        rsp_fault,
`ifdef IMEM_PERF_CNT_EN
  output logic [31:0]       fetch_count,
  output logic [31:0]       fault_count,
`endif
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_LOAD
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [IDX_W-1:0]  r_clearPtr;
  logic [IDX_W-1:0]  r_loadPtr;
  logic [XLEN-1:0]   r_mem [DEPTH];

  logic              w_fetchAccept;
  logic              w_loadAccept;
  logic              w_loadEnd;
  logic              w_loadEnter;
  logic              w_misaligned;
  logic              w_outOfRange;
  logic [ADDR_W-1:0] w_wordIdx;
  logic [IDX_W-1:0]  w_memIdx;
  logic              w_memWe;
  logic [IDX_W-1:0]  w_memWaddr;
  logic [XLEN-1:0]   w_memWdata;

  assign w_wordIdx     = fetch_addr >> 2;
  assign w_memIdx      = w_wordIdx[IDX_W-1:0];
  assign w_misaligned  = (fetch_addr[1:0] != 2'b00);
  assign w_outOfRange  = (w_wordIdx >= ADDR_W'(DEPTH));
  assign w_fetchAccept = fetch_req && (r_state == ST_IDLE);
  assign w_loadAccept  = load_valid && (r_state == ST_LOAD);
  assign w_loadEnd     = load_last || (r_loadPtr == IDX_W'(DEPTH - 1));
  assign w_loadEnter   = load_start && (r_state == ST_IDLE);

  always_comb begin
    w_nextState = r_state;
    fetch_ready = 1'b0;
    load_ready  = 1'b0;
    load_done   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      ST_CLEAR: begin
        if (r_clearPtr == IDX_W'(DEPTH - 1)) begin
          w_nextState = ST_IDLE;
        end
      end
      ST_IDLE: begin
        fetch_ready = 1'b1;
        busy        = 1'b0;
        if (load_start) begin
          w_nextState = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_ready = 1'b1;
        if (load_valid && w_loadEnd) begin
          load_done   = 1'b1;
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_CLEAR;
      r_clearPtr <= '0;
      r_loadPtr  <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == ST_CLEAR) begin
        r_clearPtr <= r_clearPtr + IDX_W'(1);
      end
      if (w_loadEnter) begin
        r_loadPtr <= '0;
      end else if (w_loadAccept) begin
        r_loadPtr <= r_loadPtr + IDX_W'(1);
      end
    end
  end

  // Single write port shared by the clear sweep and the loader; held off while reset is asserted.
  always_comb begin
    w_memWe    = 1'b0;
    w_memWaddr = r_clearPtr;
    w_memWdata = FILL_INSTR;
    if (reset) begin
      if (r_state == ST_CLEAR) begin
        w_memWe = 1'b1;
      end else if (w_loadAccept) begin
        w_memWe    = 1'b1;
        w_memWaddr = r_loadPtr;
        w_memWdata = load_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_memWe) begin
      r_mem[w_memWaddr] <= w_memWdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_instr <= FILL_INSTR;
      rsp_fault <= 2'b00;
    end else begin
      rsp_valid <= w_fetchAccept;
      if (w_fetchAccept) begin
        rsp_fault <= {w_outOfRange, w_misaligned};
        rsp_instr <= (w_outOfRange || w_misaligned) ? FILL_INSTR : r_mem[w_memIdx];
      end
    end
  end

`ifdef IMEM_PERF_CNT_EN
  // Entering LOAD wins over a fetch accepted in the same cycle, so counters start at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count <= '0;
      fault_count <= '0;
    end else if (w_loadEnter) begin
      fetch_count <= '0;
      fault_count <= '0;
    end else if (w_fetchAccept) begin
      fetch_count <= fetch_count + 32'd1;
      if (w_outOfRange || w_misaligned) begin
        fault_count <= fault_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised instruction memory: the next generation of the single-cycle core's fixed instruction ROM.
- Contents are not hard-coded. After reset they are cleared to a NOP fill value by a sweep state machine. A program is then streamed in through a valid/ready load port.
- Fetches use a request/response handshake with one-cycle registered latency and report alignment and range faults.
- Sits between the fetch stage PC and the decoder; the load port is driven by the testbench or a boot loader.

Parameters:
- XLEN, 32, instruction word width in bits.
- DEPTH, 64, number of words; must be a power of two, at least 4.
- ADDR_W, 32, fetch byte-address width.
- FILL_INSTR, 32'h00000013, clear/fault value (NOP, addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_start  in  1  request to begin a program load at word 0.
- load_valid  in  1  load_data is valid.
- load_data  in  XLEN  program word.
- load_last  in  1  marks the final word of the load.
- load_ready  out  1  block accepts a load word this cycle.
- load_done  out  1  one-cycle pulse when the load completes.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_W  byte address.
- fetch_ready  out  1  fetch is accepted this cycle.
- rsp_valid  out  1  response is valid (one-cycle pulse per accepted fetch).
- rsp_instr  out  XLEN  fetched instruction.
- rsp_fault  out  2  bit0 = misaligned, bit1 = out of range.
- busy  out  1  high in CLEAR and LOAD.

Behaviour:
- Reset (reset=0) is asynchronous and forces:
  - state=CLEAR, clear pointer=0, load pointer=0.
  - rsp_valid=0, rsp_instr=FILL_INSTR, rsp_fault=0.
  - load_ready=0, load_done=0, fetch_ready=0, busy=1.
- Reset does not touch the memory array; contents are rewritten by the CLEAR sweep.
- Reset mid-load aborts the load. The CLEAR sweep then runs again, so no words from the partial load survive.
- State CLEAR:
  - Writes FILL_INSTR to mem[ptr] and increments ptr each cycle.
  - After writing word DEPTH-1, goes to IDLE. This takes exactly DEPTH cycles after reset release.
  - fetch_ready=0; load_start is ignored.
- State IDLE:
  - fetch_ready=1, load_ready=0, busy=0.
  - load_start=1 moves to LOAD next cycle with load pointer=0.
- State LOAD:
  - load_ready=1, fetch_ready=0, busy=1.
  - Each cycle with load_valid&&load_ready writes mem[lptr]=load_data and increments lptr.
  - The load ends after the word carrying load_last=1, or after writing word DEPTH-1, whichever comes first. There is no wrap.
  - On ending: load_done pulses for one cycle and the next state is IDLE.
  - Words not written keep their prior contents.
  - load_start while already in LOAD is ignored.
- Fetch handshake:
  - A fetch is accepted when fetch_req&&fetch_ready. On the next cycle rsp_valid=1 and rsp_instr/rsp_fault carry the result.
  - Back-to-back fetches are allowed every cycle, giving full throughput.
  - When no fetch is accepted, rsp_valid=0 and rsp_instr/rsp_fault hold their last values.
- Fault rules (both bits may be set together):
  - Word index is fetch_addr>>2.
  - misaligned: fetch_addr[1:0]!=0.
  - out of range: (fetch_addr>>2)>=DEPTH.
  - On any fault, rsp_instr=FILL_INSTR.
- Simultaneous fetch_req and load_start in IDLE: the fetch is accepted and reads the pre-load contents; LOAD begins next cycle.
- Read/write ordering: a fetch accepted in the same cycle as a write (in IDLE only the CLEAR final write) returns the old contents.

Optional Feature:
- Macro IMEM_PERF_CNT_EN.
- Defined: adds two outputs, fetch_count[31:0] and fault_count[31:0].
  - Each increments by 1 on every accepted fetch, and on every accepted faulting fetch, respectively.
  - Both wrap modulo 2^32 and reset to 0.
  - Both clear to 0 on entry to LOAD.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Release reset, hold fetch_req=1 -> busy=1 and fetch_ready=0 for exactly 64 cycles, then fetch_ready=1. A fetch of 0x00 returns 32'h00000013 with rsp_fault=0.
- load_start, then stream 0x00500293, 0x00600313, 0x006282B3 with load_last on the third word -> load_done pulses once. Fetches of 0x0/0x4/0x8/0xC return those three words, then 32'h00000013.
- Back-to-back fetches 0x4, 0x8 on consecutive cycles -> rsp_valid high two consecutive cycles with the matching data, one-cycle latency each.
- Fetch 0x06 -> rsp_fault=2'b01. Fetch 0x100 -> 2'b10. Fetch 0x102 -> 2'b11. All return rsp_instr=32'h00000013.
- Assert reset after the second of five load words -> all outputs return to reset values and the CLEAR sweep repeats. Afterwards, fetch 0x0 returns 32'h00000013.
- Load 64 words with load_last never asserted -> load_done pulses after word 63 and the 65th load_valid is not accepted (load_ready=0).
